// File: rtl/peak_sweep_tracker.sv
// peak_sweep_tracker: sweeps a theta/phi grid in serpentine order. At each
// position it waits for the settle time, takes one ADC sample and keeps the
// largest value with its position. When the sweep ends it parks on the peak.
// Optional build macro PEAK_AVG_EN: average 4 samples per position.
// dbg_state exposes the FSM state for debug.
// Handshake: a sample is consumed on every clk edge where sample_req=1 and
// sample_valid=1 and abort=0; sample_valid in any other cycle is ignored.
module peak_sweep_tracker #(
    parameter int DATA_W      = 12,
    parameter int THETA_STEPS = 180,
    parameter int PHI_STEPS   = 90,
    parameter int SETTLE_CYC  = 1000,
    localparam int TW = $clog2((THETA_STEPS < 2) ? 2 : THETA_STEPS),
    localparam int PW = $clog2((PHI_STEPS < 2) ? 2 : PHI_STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              sample_req,
    output logic [TW-1:0]     theta,
    output logic [PW-1:0]     phi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_val,
    output logic [TW-1:0]     max_theta,
    output logic [PW-1:0]     max_phi,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] THETA_LAST  = TW'(THETA_STEPS - 1);
    localparam logic [PW-1:0] PHI_LAST    = PW'(PHI_STEPS - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_settle_cnt;
    logic [TW-1:0]     r_theta;
    logic [PW-1:0]     r_phi;
    logic [DATA_W-1:0] r_max_val;
    logic [TW-1:0]     r_max_theta;
    logic [PW-1:0]     r_max_phi;

    logic              w_start_ok;
    logic              w_take;
    logic              w_pos_done;
    logic              w_row_end;
    logic              w_final;
    logic [DATA_W-1:0] w_value;

    // Odd rows run theta downwards, so their row end is theta=0.
    assign w_row_end  = r_phi[0] ? (r_theta == '0) : (r_theta == THETA_LAST);
    assign w_final    = w_row_end && (r_phi == PHI_LAST);
    assign w_start_ok = start && !abort;
    assign w_take     = (r_state == S_SAMPLE) && sample_valid && !abort;

`ifdef PEAK_AVG_EN
    logic [DATA_W+1:0] r_acc;
    logic [1:0]        r_acc_cnt;
    logic [DATA_W+1:0] w_sum;

    assign w_sum      = r_acc + {2'b00, sample};
    assign w_pos_done = w_take && (r_acc_cnt == 2'd3);
    assign w_value    = w_sum[DATA_W+1:2];

    // Accumulate four samples per position; abort or a new sweep discards them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (abort || (r_state == S_IDLE)) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
        end else if (w_take) begin
            r_acc     <= w_pos_done ? '0 : w_sum;
            r_acc_cnt <= r_acc_cnt + 2'd1;
        end
    end
`else
    assign w_pos_done = w_take;
    assign w_value    = sample;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state logic and state-decoded outputs; abort wins everywhere but IDLE.
    always_comb begin
        w_next_state = r_state;
        sample_req   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_start_ok) w_next_state = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort)                   w_next_state = S_IDLE;
                else if (r_settle_cnt == '0) w_next_state = S_SAMPLE;
            end
            S_SAMPLE: begin
                sample_req = 1'b1;
                if (abort)           w_next_state = S_IDLE;
                else if (w_pos_done) w_next_state = w_final ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                done         = !abort;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Position, settle counter and peak registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= '0;
            r_theta      <= '0;
            r_phi        <= '0;
            r_max_val    <= '0;
            r_max_theta  <= '0;
            r_max_phi    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_theta      <= '0;
                        r_phi        <= '0;
                        r_max_val    <= '0;
                        r_max_theta  <= '0;
                        r_max_phi    <= '0;
                        r_settle_cnt <= SETTLE_LOAD;
                    end
                end
                S_SETTLE: begin
                    if (!abort && (r_settle_cnt != '0))
                        r_settle_cnt <= r_settle_cnt - CW'(1);
                end
                S_SAMPLE: begin
                    if (w_pos_done) begin
                        // Strict compare keeps the earliest position on ties.
                        if (w_value > r_max_val) begin
                            r_max_val   <= w_value;
                            r_max_theta <= r_theta;
                            r_max_phi   <= r_phi;
                        end
                        if (!w_final) begin
                            r_settle_cnt <= SETTLE_LOAD;
                            if (w_row_end)     r_phi   <= r_phi + PW'(1);
                            else if (r_phi[0]) r_theta <= r_theta - TW'(1);
                            else               r_theta <= r_theta + TW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!abort) begin
                        r_theta <= r_max_theta;
                        r_phi   <= r_max_phi;
                    end
                end
                default: ;
            endcase
        end
    end

    assign theta     = r_theta;
    assign phi       = r_phi;
    assign max_val   = r_max_val;
    assign max_theta = r_max_theta;
    assign max_phi   = r_max_phi;
    assign dbg_state = r_state;

endmodule

// File: doc/peak_sweep_tracker.md
PEAK_SWEEP_TRACKER -- requirements
Module: peak_sweep_tracker

Interface
REQ-001 Parameter DATA_W, default 12: ADC sample width in bits.
REQ-002 Parameter THETA_STEPS, default 180: horizontal positions per row, at least 2.
REQ-003 Parameter PHI_STEPS, default 90: vertical rows, at least 1.
REQ-004 Parameter SETTLE_CYC, default 1000: cycles waited after each move before sampling, at least 1.
REQ-005 Derived widths: TW = clog2(THETA_STEPS) and PW = clog2(PHI_STEPS), each at least 1.
REQ-006 Clock and reset: reset is asynchronous and active-high; the clock is clk.
REQ-007 Port list (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: async active-high reset.
- start, in, 1: begin sweep; sampled only in IDLE.
- abort, in, 1: cancel sweep.
- sample, in, DATA_W: ADC code.
- sample_valid, in, 1: sample is present.
- sample_req, out, 1: block is ready to accept a sample.
- theta, out, TW: commanded horizontal position.
- phi, out, PW: commanded vertical position.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse on sweep completion.
- max_val, out, DATA_W: peak value found.
- max_theta, out, TW: theta at the peak.
- max_phi, out, PW: phi at the peak.

Function
REQ-008 The FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE.
REQ-009 IDLE with start=1: clear max_val, max_theta and max_phi to 0; set theta=0 and phi=0; go to SETTLE next cycle.
REQ-010 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to SAMPLE.
REQ-011 In SAMPLE, sample_req=1; a sample is accepted on any cycle with sample_req=1 and sample_valid=1.
REQ-012 sample_valid outside SAMPLE SHALL be ignored.
REQ-013 On acceptance, if the value is strictly greater than max_val, update max_val, max_theta and max_phi with the value and the current theta/phi in the same edge.
REQ-014 On ties, the earlier position SHALL be kept.
REQ-015 Sweep order is serpentine:
- On even phi rows, theta increments.
- On odd phi rows, theta decrements.
- At the end of a row, theta holds and phi increments.
REQ-016 After an acceptance at a non-final position, the move SHALL occur on the same edge and the FSM returns to SETTLE.
REQ-017 After acceptance at the final position (phi=PHI_STEPS-1 and row-end theta), go to DONE.
REQ-018 DONE SHALL:
- assert done for exactly 1 cycle,
- load theta=max_theta and phi=max_phi (park on the peak),
- go to IDLE on the next cycle.
REQ-019 In IDLE, theta and phi SHALL hold their last values.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 abort=1 in any non-IDLE state SHALL:
- go to IDLE next cycle,
- not pulse done,
- retain partial max outputs,
- hold theta and phi.
REQ-022 If abort and acceptance occur in the same cycle, abort wins: no max update and no move.
REQ-023 abort in IDLE SHALL be ignored; start and abort together in IDLE stays in IDLE.
REQ-024 The settle counter SHALL be wide enough for SETTLE_CYC and reload on every SETTLE entry.

Reset
REQ-025 Reset SHALL force state IDLE with all of these at 0: theta, phi, max_val, max_theta, max_phi, busy, done, sample_req and the internal counters/accumulator.
REQ-026 Reset asserted mid-sweep SHALL take effect immediately; no done pulse.

Configuration
REQ-027 With macro PEAK_AVG_EN defined:
- SAMPLE accepts 4 samples per position into a DATA_W+2-bit accumulator.
- The value compared and stored is the accumulator shifted right by 2 (truncating).
- The move happens only after the 4th acceptance.
- abort discards the partial accumulator.
REQ-028 Without PEAK_AVG_EN, a single sample is accepted per position and no accumulator is built.

Verification (THETA_STEPS=4, PHI_STEPS=3, SETTLE_CYC=2, DATA_W=12, macro undefined unless stated)
REQ-029 Pulse start, sample_valid held 1, samples 0 except 0x7FF at (theta=2, phi=1):
- 12 acceptances in serpentine order (0,0)(1,0)(2,0)(3,0)(3,1)(2,1)(1,1)(0,1)(0,2)(1,2)(2,2)(3,2).
- Result: done pulse, max_val=0x7FF, max_theta=2, max_phi=1, theta/phi parked at 2/1.
REQ-030 Samples 0x100 at (1,0) and 0x100 at (3,2), all others lower -> max_theta=1, max_phi=0 (tie keeps earliest).
REQ-031 sample_valid low for 5 cycles in SAMPLE:
- sample_req stays 1, theta holds.
- No update until valid rises.
- Each position lasts SETTLE_CYC plus the wait cycles.
REQ-032 abort at the 5th acceptance cycle -> IDLE next cycle, no done, theta=3, phi=1, max from the first 4 samples only; a later start clears max_val to 0.
REQ-033 Reset mid-SETTLE -> all outputs 0 and busy=0 immediately; start pulsed during SAMPLE is ignored.
REQ-034 PEAK_AVG_EN defined, samples 10, 11, 12, 13 at (0,0) -> max_val=11, with 48 total acceptances per sweep.
